// File: rtl/trap_csr_unit_if.sv
// Bus bundle between the EXE stage and the machine-mode trap/CSR unit.
// master: EXE side (drives requests, PC, CSR op); slave: trap_csr_unit.
interface trap_csr_unit_if #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq_i;
  logic [NUM_IRQ-1:0] irq_ack;
  logic               exc_i;
  logic [4:0]         exc_cause;
  logic [XLEN-1:0]    exc_tval;
  logic               mret_i;
  logic [XLEN-1:0]    pc_i;
  logic [1:0]         csr_op;
  logic [11:0]        csr_addr;
  logic [XLEN-1:0]    csr_wdata;
  logic [XLEN-1:0]    csr_rdata;
  logic               csr_hit;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               flush;

  modport master (
    output irq_i, exc_i, exc_cause, exc_tval, mret_i, pc_i,
           csr_op, csr_addr, csr_wdata,
    input  irq_ack, csr_rdata, csr_hit, redirect_valid, redirect_pc, flush
  );

  modport slave (
    input  irq_i, exc_i, exc_cause, exc_tval, mret_i, pc_i,
           csr_op, csr_addr, csr_wdata,
    output irq_ack, csr_rdata, csr_hit, redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/trap_csr_unit.sv
// Machine-mode trap and CSR controller: fixed-priority level interrupts,
// synchronous exceptions, mret, and the M-mode CSR file for CSR instructions.
// Ports: clk, reset (async, active-low), bus (trap_csr_unit_if.slave):
//   irq_i/irq_ack, exc_i/exc_cause/exc_tval, mret_i, pc_i, csr_op/csr_addr/
//   csr_wdata/csr_rdata/csr_hit, redirect_valid/redirect_pc, flush.
module trap_csr_unit #(
  parameter int unsigned     XLEN        = 64,
  parameter int unsigned     NUM_IRQ     = 4,
  parameter int unsigned     CAUSE_BASE  = 11,
  parameter bit              VECTORED_EN = 1'b1,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter bit              MIE_RESET   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  trap_csr_unit_if.slave   bus
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  // Without vectoring the mode field is held at zero, including at reset.
  localparam logic [XLEN-1:0] MTVEC_INIT =
    VECTORED_EN ? MTVEC_RESET : {MTVEC_RESET[XLEN-1:2], 2'b00};

  typedef enum logic [1:0] {S_IDLE, S_TRAP, S_FLUSH} state_e;

  state_e             state_q, state_d;
  logic               mstatus_mie_q, mstatus_mie_d;
  logic               mpie_q, mpie_d;
  logic [NUM_IRQ-1:0] irq_en_q, irq_en_d;
  logic [XLEN-1:0]    mtvec_q, mtvec_d;
  logic [XLEN-1:0]    mscratch_q, mscratch_d;
  logic [XLEN-1:0]    mepc_q, mepc_d;
  logic [XLEN-1:0]    mcause_q, mcause_d;
  logic [XLEN-1:0]    mtval_q, mtval_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic               flush_q, flush_d;
  logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d;
  logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;

  logic               irq_pend_c;
  logic               irq_take_c;
  logic [NUM_IRQ-1:0] irq_onehot_c;
  logic [XLEN-1:0]    irq_code_c;
  logic [XLEN-1:0]    csr_rdata_c;
  logic               csr_hit_c;
  logic [XLEN-1:0]    csr_wval_c;
  logic [XLEN-1:0]    mtvec_base_c;
  logic               vec_mode_c;

  // Lowest-numbered enabled pending line wins; global MIE gates the take.
  always_comb begin
    irq_pend_c   = 1'b0;
    irq_onehot_c = '0;
    irq_code_c   = '0;
    for (int unsigned k = 0; k < NUM_IRQ; k++) begin
      if (!irq_pend_c && bus.irq_i[k] && irq_en_q[k]) begin
        irq_pend_c      = 1'b1;
        irq_onehot_c[k] = 1'b1;
        irq_code_c      = XLEN'(CAUSE_BASE + k);
      end
    end
    irq_take_c = irq_pend_c && mstatus_mie_q;
  end

  // Combinational CSR read of the current (pre-update) value.
  always_comb begin
    csr_hit_c   = 1'b1;
    csr_rdata_c = '0;
    case (bus.csr_addr)
      ADDR_MSTATUS: begin
        csr_rdata_c[3]     = mstatus_mie_q;
        csr_rdata_c[7]     = mpie_q;
        csr_rdata_c[12:11] = 2'b11;
      end
      ADDR_MIE:      csr_rdata_c[CAUSE_BASE +: NUM_IRQ] = irq_en_q;
      ADDR_MTVEC:    csr_rdata_c = mtvec_q;
      ADDR_MSCRATCH: csr_rdata_c = mscratch_q;
      ADDR_MEPC:     csr_rdata_c = mepc_q;
      ADDR_MCAUSE:   csr_rdata_c = mcause_q;
      ADDR_MTVAL:    csr_rdata_c = mtval_q;
      ADDR_MIP:      csr_rdata_c[CAUSE_BASE +: NUM_IRQ] = bus.irq_i;
      default:       csr_hit_c = 1'b0;
    endcase
  end

  // Value a write/set/clear would produce from the old CSR contents.
  always_comb begin
    case (bus.csr_op)
      2'b01:   csr_wval_c = bus.csr_wdata;
      2'b10:   csr_wval_c = csr_rdata_c | bus.csr_wdata;
      2'b11:   csr_wval_c = csr_rdata_c & ~bus.csr_wdata;
      default: csr_wval_c = csr_rdata_c;
    endcase
  end

  // Modes 10/11 fall back to direct.
  always_comb begin
    mtvec_base_c = {mtvec_q[XLEN-1:2], 2'b00};
    vec_mode_c   = VECTORED_EN && (mtvec_q[1:0] == 2'b01);
  end

  // Next-state, CSR update and registered-output logic.
  always_comb begin
    state_d          = state_q;
    mstatus_mie_d    = mstatus_mie_q;
    mpie_d           = mpie_q;
    irq_en_d         = irq_en_q;
    mtvec_d          = mtvec_q;
    mscratch_d       = mscratch_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    redirect_valid_d = 1'b0;
    flush_d          = 1'b0;
    irq_ack_d        = '0;
    redirect_pc_d    = redirect_pc_q;

    case (state_q)
      S_IDLE: begin
        if (bus.exc_i || irq_take_c) begin
          // Trap entry squashes any CSR op and mret in this cycle.
          state_d          = S_TRAP;
          redirect_valid_d = 1'b1;
          flush_d          = 1'b1;
          mepc_d           = {bus.pc_i[XLEN-1:2], 2'b00};
          mpie_d           = mstatus_mie_q;
          mstatus_mie_d    = 1'b0;
          if (bus.exc_i) begin
            mcause_d      = XLEN'(bus.exc_cause);
            mtval_d       = bus.exc_tval;
            redirect_pc_d = mtvec_base_c;
          end else begin
            mcause_d      = {1'b1, irq_code_c[XLEN-2:0]};
            mtval_d       = '0;
            irq_ack_d     = irq_onehot_c;
            redirect_pc_d = vec_mode_c ? mtvec_base_c + (irq_code_c << 2)
                                       : mtvec_base_c;
          end
        end else begin
          if ((bus.csr_op != 2'b00) && csr_hit_c) begin
            case (bus.csr_addr)
              ADDR_MSTATUS: begin
                mstatus_mie_d = csr_wval_c[3];
                mpie_d        = csr_wval_c[7];
              end
              ADDR_MIE:      irq_en_d   = csr_wval_c[CAUSE_BASE +: NUM_IRQ];
              ADDR_MTVEC:    mtvec_d    = VECTORED_EN ? csr_wval_c
                                                      : {csr_wval_c[XLEN-1:2], 2'b00};
              ADDR_MSCRATCH: mscratch_d = csr_wval_c;
              ADDR_MEPC:     mepc_d     = {csr_wval_c[XLEN-1:2], 2'b00};
              ADDR_MCAUSE:   mcause_d   = csr_wval_c;
              ADDR_MTVAL:    mtval_d    = csr_wval_c;
              default:       ;
            endcase
          end
          // Return uses the pre-update MPIE/mepc and overrides a same-cycle mstatus write.
          if (bus.mret_i) begin
            state_d          = S_TRAP;
            redirect_valid_d = 1'b1;
            flush_d          = 1'b1;
            mstatus_mie_d    = mpie_q;
            mpie_d           = 1'b1;
            redirect_pc_d    = mepc_q;
          end
        end
      end
      S_TRAP: begin
        flush_d = 1'b1;
        state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and CSR registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      mstatus_mie_q    <= MIE_RESET;
      mpie_q           <= 1'b0;
      irq_en_q         <= '1;
      mtvec_q          <= MTVEC_INIT;
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      irq_ack_q        <= '0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      mstatus_mie_q    <= mstatus_mie_d;
      mpie_q           <= mpie_d;
      irq_en_q         <= irq_en_d;
      mtvec_q          <= mtvec_d;
      mscratch_q       <= mscratch_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
      irq_ack_q        <= irq_ack_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign bus.csr_rdata      = csr_rdata_c;
  assign bus.csr_hit        = csr_hit_c;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.irq_ack        = irq_ack_q;

endmodule

// File: doc/trap_csr_unit.md
Name: trap_csr_unit

Overview:
- Machine-mode trap and CSR controller for the riscv64 core; replaces the core's hard-wired single-interrupt/mret logic.
- Parametrised interrupt line count with fixed priority and direct/vectored mtvec.
- Synchronous exception entry, mret return, and a CSR read/write port for CSR instructions.
- Sits beside the EXE stage; drives PC redirect and bubble flush back into it.

Parameters:
- XLEN, 64, data/PC width.
- NUM_IRQ, 4, number of level-sensitive interrupt lines (1..16).
- CAUSE_BASE, 11, mcause code of line 0; line k has code CAUSE_BASE+k; CAUSE_BASE+NUM_IRQ <= XLEN.
- VECTORED_EN, 1, 1 = mtvec mode 01 honoured; 0 = mode bits read 0.
- MTVEC_RESET, 0, reset value of mtvec.
- MIE_RESET, 1, reset value of mstatus.MIE; mie enable bits for all lines reset to 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- irq_i  in  NUM_IRQ  level interrupt requests.
- irq_ack  out  NUM_IRQ  one-hot, 1-cycle ack of the taken line.
- exc_i  in  1  synchronous exception from EXE this cycle.
- exc_cause  in  5  exception code.
- exc_tval  in  XLEN  trap value.
- mret_i  in  1  EXE executing mret.
- pc_i  in  XLEN  PC of the instruction in EXE.
- csr_op  in  2  00 none, 01 write, 10 set, 11 clear.
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  write/set/clear operand.
- csr_rdata  out  XLEN  combinational read of csr_addr (old value).
- csr_hit  out  1  csr_addr is implemented.
- redirect_valid  out  1  1-cycle PC redirect.
- redirect_pc  out  XLEN  redirect target.
- flush  out  1  EXE must bubble this cycle.

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: only MIE[3] and MPIE[7] writable; MPP[12:11] reads 11; other bits read 0.
  - mie 0x304: bits CAUSE_BASE..CAUSE_BASE+NUM_IRQ-1 writable; other bits read 0.
  - mtvec 0x305.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] forced 0.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: read-only, bit CAUSE_BASE+k = irq_i[k].
- Unimplemented address: csr_hit=0, read 0, write ignored.
- CSR write/set/clear commits at the clock edge ending the request cycle.
- FSM states: IDLE, TRAP, FLUSH.
- In IDLE, evaluation in cycle N, in priority order:
  - exc_i: take exception. Taken regardless of MIE.
  - Otherwise, if mstatus.MIE and any (irq_i[k] & mie[CAUSE_BASE+k]): take the interrupt on the lowest such k.
  - Otherwise, if mret_i: return.
  - Otherwise: stay in IDLE.
- Trap take, updates at the edge ending N:
  - mepc <= pc_i.
  - mcause <= {0, exc_cause} for an exception; {1, CAUSE_BASE+k} for an interrupt.
  - mtval <= exc_tval for an exception; 0 for an interrupt.
  - MPIE <= MIE; MIE <= 0.
  - Any CSR op in cycle N is dropped (instruction squashed).
  - mret_i in cycle N is ignored; mepc = mret's PC, so mret re-executes after return.
  - Next state TRAP.
- Return, updates at the edge ending N:
  - MIE <= MPIE; MPIE <= 1.
  - Next state TRAP with target = mepc.
- TRAP (cycle N+1):
  - redirect_valid=1.
  - redirect_pc for a trap: {mtvec[XLEN-1:2],00}, or that base + 4*cause when mtvec[1:0]=01, VECTORED_EN=1 and the trap is an interrupt.
  - redirect_pc for a return: mepc.
  - irq_ack[k]=1 for an interrupt take.
  - flush=1.
  - Next state FLUSH.
- FLUSH (cycle N+2): flush=1; next state IDLE.
- In TRAP/FLUSH: exc_i, mret_i, csr_op and irq_i are ignored (not latched); a still-asserted irq is re-evaluated in IDLE.
- mtvec mode 1x or 11: treated as direct. mtvec write of mode 01 with VECTORED_EN=0: stores mode 00.
- Reset values (asynchronous):
  - State IDLE.
  - Outputs redirect_valid=0, flush=0, irq_ack=0, redirect_pc=0.
  - mstatus.MIE=MIE_RESET, MPIE=0.
  - mie line bits all 1.
  - mtvec=MTVEC_RESET.
  - mepc, mcause, mtval, mscratch = 0.
- Reset mid-TRAP/FLUSH aborts the sequence; no ack is emitted after reset.

Test Plan:
- Reset, then irq_i=0001 with pc_i=0x8000_0010 → N+1: redirect_valid=1, redirect_pc=0, irq_ack=0001; N+2: flush=1; mepc=0x8000_0010, mcause=0x8000_0000_0000_000B, MIE=0, MPIE=1.
- mtvec=0x100|01, irq_i=1010 → line 1 wins: mcause low bits 0x0C, redirect_pc=0x130, irq_ack=0010; repeat with VECTORED_EN=0 → redirect_pc=0x100.
- exc_i=1 (cause 2, tval 0xDEAD) same cycle as irq_i=0001 → exception wins: mcause=2, mtval=0xDEAD, irq_ack=0; interrupt is taken after return once MIE=1.
- After trap entry, mret_i with mepc=0x8000_0010 → redirect_pc=0x8000_0010, MIE=1, MPIE=1; MIE=0 beforehand blocks irq_i=0001 until then.
- CSR ops: set mie with 0x800, clear with 0x800, write mscratch 0x55; read 0x7C0 → csr_hit=0, rdata=0; CSR write coincident with trap take → dropped.
- Assert reset during TRAP → outputs 0, state IDLE, mepc=0 next cycle.
